// File: rtl/lane_streamer.sv
// Reads a 5x5 array of W-bit lanes from a registered-read state memory and
// streams them as 25 words (x fastest) on a pushout/stopin/firstout interface.
module lane_streamer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [2:0]   ax,
    output logic [2:0]   ay,
    input  logic [W-1:0] rd,
    output logic         pushout,
    input  logic         stopin,
    output logic         firstout,
    output logic [W-1:0] dout
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state;
    logic [4:0]   ric;
    logic [4:0]   oc;
    logic         inflight;
    logic [1:0]   occ;
    logic [W-1:0] tail;

    logic         xfer;
    logic         issue;
    logic         last;
    logic [1:0]   occ_next;
    logic [1:0]   fill;
    logic [4:0]   oc_next;
    logic [W-1:0] head_next;
    logic [W-1:0] tail_next;

    // dout is the buffer head; tail is the second entry. A read is issued only
    // if buffered words plus the in-flight read still fit after this cycle's pop.
    always_comb begin
        xfer      = pushout && !stopin;
        occ_next  = occ + {1'b0, inflight} - {1'b0, xfer};
        fill      = occ - {1'b0, xfer};
        issue     = (state == RUN) && (ric < 5'd25) && (occ_next < 2'd2);
        last      = xfer && (oc == 5'd24);
        oc_next   = last ? '0 : oc + {4'b0, xfer};
        head_next = dout;
        tail_next = tail;
        if (xfer) begin
            head_next = tail;
        end
        if (inflight) begin
            if (fill == 2'd0) begin
                head_next = rd;
            end else begin
                tail_next = rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pushout  <= 1'b0;
            firstout <= 1'b0;
            dout     <= '0;
            tail     <= '0;
            ax       <= '0;
            ay       <= '0;
            ric      <= '0;
            oc       <= '0;
            inflight <= 1'b0;
            occ      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    ric   <= '0;
                    oc    <= '0;
                    ax    <= '0;
                    ay    <= '0;
                end
            end else begin
                inflight <= issue;
                occ      <= occ_next;
                pushout  <= (occ_next != 2'd0);
                firstout <= (occ_next != 2'd0) && (oc_next == 5'd0);
                dout     <= head_next;
                tail     <= tail_next;
                oc       <= oc_next;
                if (issue) begin
                    ric <= ric + 5'd1;
                    // Address wraps to (0,0) after lane 24 so it idles at zero.
                    if (ax == 3'd4) begin
                        ax <= '0;
                        ay <= (ay == 3'd4) ? 3'd0 : ay + 3'd1;
                    end else begin
                        ax <= ax + 3'd1;
                    end
                end
                if (last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_streamer.sv
// Self-checking bench for lane_streamer: a transfer-level model predicts every
// output each cycle; directed scenarios pin the latencies with literal values.
module tb_lane_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  ax;
    logic [2:0]  ay;
    logic [63:0] rd;
    logic        pushout;
    logic        stopin;
    logic        firstout;
    logic [63:0] dout;

    lane_streamer #(.W(64)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ax(ax), .ay(ay), .rd(rd), .pushout(pushout), .stopin(stopin),
        .firstout(firstout), .dout(dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [63:0] mem [25];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Registered-read state memory.
    always @(posedge clk) begin
        int idx;
        idx = int'(ax) + 5 * int'(ay);
        rd <= (idx < 25) ? mem[idx] : 64'hdead_beef_dead_beef;
    end

    // Model: a run begins at the accepting edge; words are offered from two
    // cycles later, one lane per accepting cycle, in index order.
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_age = 0;
    int   m_xfers = 0;
    int   m_last_done = -1;

    always @(posedge clk) begin
        logic xf;
        cyc++;
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_age = 0; m_xfers = 0;
        end else begin
            xf = m_busy && (m_age >= 2) && !stopin;
            m_done = 1'b0;
            if (m_busy) begin
                m_age++;
                if (xf) begin
                    m_xfers++;
                    if (m_xfers == 25) begin
                        m_busy = 1'b0; m_done = 1'b1; m_last_done = cyc;
                    end
                end
            end else if (start) begin
                m_busy = 1'b1; m_age = 0; m_xfers = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int push_cnt, first_push, first_cnt, done_cnt, last_done, hold7;

    always @(negedge clk) begin
        logic ep;
        if (!reset) begin
            check("reset_ctl", {busy, done, pushout, firstout, ax, ay}, 64'd0);
            check("reset_dout", dout, 64'd0);
        end else begin
            ep = m_busy && (m_age >= 2);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("pushout", pushout, ep);
            if (ep) begin
                check("dout", dout, mem[m_xfers]);
                check("firstout", firstout, m_xfers == 0);
            end else begin
                check("firstout_idle", firstout, 1'b0);
            end
            if (!m_busy) check("addr_idle", {ax, ay}, 64'd0);
            if (pushout) begin
                push_cnt++;
                if (first_push < 0) first_push = cyc;
            end
            if (firstout) first_cnt++;
            if (done) begin
                done_cnt++;
                last_done = cyc;
            end
            if (pushout && dout == mem[7]) hold7++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        push_cnt = 0; first_push = -1; first_cnt = 0; done_cnt = 0; last_done = -1; hold7 = 0;
    endtask

    task automatic kick(output int s0);
        start = 1'b1;
        s0 = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, rel;
        reset = 1'b0; start = 1'b0; stopin = 1'b0;
        for (int i = 0; i < 25; i++) mem[i] = (64'(i / 5) << 56) + 64'(i);
        clear_stats();
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Unstalled run.
        clear_stats();
        kick(s0);
        repeat (40) tick();
        check("t1_done_cycle", last_done, s0 + 27);
        check("t1_model_done", m_last_done, s0 + 27);
        check("t1_push_count", push_cnt, 25);
        check("t1_first_push", first_push, s0 + 2);
        check("t1_first_count", first_cnt, 1);
        check("t1_lane24", mem[24], 64'h0400_0000_0000_0018);

        // Three-cycle stall while lane 7 is offered.
        clear_stats();
        kick(s0);
        for (int i = 0; i < 45; i++) begin
            rel = cyc - s0;
            stopin = (rel >= 9 && rel <= 11);
            tick();
        end
        check("t2_done_cycle", last_done, s0 + 30);
        check("t2_hold7", hold7, 4);

        // Ten stall cycles while lane 0 is offered.
        clear_stats();
        kick(s0);
        for (int i = 0; i < 50; i++) begin
            rel = cyc - s0;
            stopin = (rel >= 2 && rel <= 11);
            tick();
        end
        check("t3_done_cycle", last_done, s0 + 37);
        check("t3_first_held", first_cnt, 11);

        // Alternating backpressure.
        clear_stats();
        kick(s0);
        for (int i = 0; i < 65; i++) begin
            rel = cyc - s0;
            stopin = (rel % 2 == 1);
            tick();
        end
        stopin = 1'b0;
        check("t4_done_window", (last_done >= s0 + 51) && (last_done <= s0 + 53), 1'b1);
        check("t4_done_count", done_cnt, 1);

        // Start while busy is ignored; start in the done cycle is accepted.
        clear_stats();
        kick(s0);
        for (int i = 0; i < 70; i++) begin
            rel = cyc - s0;
            start = (rel == 10) || (rel == 27);
            tick();
        end
        start = 1'b0;
        check("t5_done_count", done_cnt, 2);
        check("t5_second_done", last_done, s0 + 55);
        check("t5_first_count", first_cnt, 2);

        // Asynchronous reset at lane 12, then a fresh run.
        clear_stats();
        kick(s0);
        while (cyc - s0 < 14) tick();
        check("t6_lane12", dout, mem[12]);
        reset = 1'b0;
        #1;
        check("t6_async_ctl", {busy, done, pushout, firstout, ax, ay}, 64'd0);
        check("t6_async_dout", dout, 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        clear_stats();
        kick(s0);
        repeat (35) tick();
        check("t6_restart_done", last_done, s0 + 27);
        check("t6_restart_first", first_cnt, 1);

        // Randomized contents, backpressure and start pulses.
        for (int i = 0; i < 25; i++) mem[i] = {$urandom, $urandom};
        clear_stats();
        for (int r = 0; r < 4; r++) begin
            kick(s0);
            for (int i = 0; i < 150; i++) begin
                stopin = ($urandom_range(0, 2) == 0);
                start  = ($urandom_range(0, 15) == 0);
                tick();
            end
            start = 1'b0; stopin = 1'b0;
            repeat (60) tick();
        end
        check("t7_runs_completed", done_cnt >= 4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
